register1024_reader: RTL
========================

# register1024_reader

Read-side counterpart of the 1024-bit operand register in the matrix-multiplication accelerator. On a start pulse it snapshots a 1024-bit register image and streams it out as narrow words over a valid/ready handshake, LSB word first. It sits between the 1024-bit result/operand register and any narrow consumer (bus bridge, output FIFO, host readback path).

## Interface
- DATA_W, 1024, width of the captured register image; must be an integer multiple of WORD_W
- WORD_W, 32, width of each output beat
- BEATS (derived localparam), DATA_W/WORD_W = 32, beats per transfer
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- reader_start  input  1  request to capture reader_data_in; honoured only when idle
- reader_data_in  input  DATA_W  register image, normally driven by register_data_out
- reader_busy  output  1  high from the cycle after an accepted start until the final beat is accepted
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  consumer accepts the beat this cycle when out_valid is also high
- out_data  output  WORD_W  current beat
- out_last  output  1  high with out_valid on the final beat (index BEATS-1)
- reader_done  output  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, SEND.
- IDLE: out_valid=0, reader_busy=0. When reader_start=1, capture reader_data_in into a DATA_W shadow register, clear beat counter, go to SEND.
- SEND: out_valid=1, out_data=shadow[WORD_W-1:0]. On out_valid&&out_ready, shift shadow right by WORD_W and increment the beat counter.
- Beat k carries reader_data_in[k*WORD_W +: WORD_W] as captured at start.
- out_last=1 exactly when the beat counter equals BEATS-1 in SEND.
- On acceptance of the last beat: go to IDLE, assert reader_done for the next cycle only.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last, and the beat index hold stable. out_valid never drops before acceptance.
- reader_start in SEND is ignored, including in the cycle the last beat is accepted. Changes to reader_data_in after capture have no effect.
- Beat counter width is clog2(BEATS). There is no wrap within a transfer; the counter clears on capture.
- Reset, including mid-transfer: state=IDLE, and out_valid, out_last, reader_busy, reader_done, and out_data all go to 0. The in-flight transfer is abandoned with no done pulse.

## Timing
- reader_start sampled high in IDLE at edge N:
  - cycle N+1: out_valid=1, beat 0, reader_busy=1.
- With out_ready held 1:
  - beat k is presented in cycle N+1+k.
  - out_last is high in cycle N+BEATS (N+32).
  - in cycle N+BEATS+1: reader_done=1, reader_busy=0, out_valid=0.
  - a reader_start sampled in cycle N+BEATS+1 is accepted.
- Minimum transfer is BEATS+1 cycles start-to-done; start-to-start throughput is BEATS+1 cycles.
- No combinational path from out_ready to out_valid or out_data. out_data is registered from the shadow.

## Structure
- Shared package (accelerator package): DATA_W/WORD_W defaults and the reader state enum (IDLE, SEND).
- Single module, no sub-module. The shift-register datapath plus the beat counter and 2-state FSM stay well within 200 lines.

## Test plan
- Reset values: assert rst for 2 cycles with reader_start=1. Required: out_valid, out_last, reader_busy, reader_done, and out_data are all 0, and no capture occurs.
- Full-speed stream:
  - Stimulus: reader_data_in=1024'h1234567890ABCDEF0123456789ABCDEF, start at N, out_ready=1.
  - Beats 0–3 = 32'h89ABCDEF, 32'h01234567, 32'h90ABCDEF, 32'h12345678.
  - Beats 4–31 = 0.
  - out_last only at N+32; reader_done pulse at N+33.
- Backpressure:
  - Stimulus: same data, out_ready toggling 0,1,0,1 from N+1.
  - Each beat held 2 cycles with out_data stable; 32 beats accepted.
  - out_last on the 32nd; reader_done is one cycle after that acceptance.
- Capture isolation: change reader_data_in to all-ones at N+2 and pulse reader_start at N+5. Required: stream is unchanged from the full-speed case and the start is ignored.
- Reset mid-transfer: rst=1 after beat 10 is accepted. Required next cycle: out_valid=0, reader_busy=0, and no reader_done. A new start restarts from beat 0 = 32'h89ABCDEF.
- Back-to-back: second start in the reader_done cycle. Required: out_valid high again the following cycle with beat 0 of the new data.

Source files
------------

// File: rtl/register1024_reader_pkg.sv
// Shared accelerator definitions used by the 1024-bit register read path.
// Holds default widths and the reader state encoding.
package register1024_reader_pkg;

    localparam int READER_DATA_W = 1024;
    localparam int READER_WORD_W = 32;

    typedef enum logic [0:0] {
        READER_IDLE = 1'b0,
        READER_SEND = 1'b1
    } reader_state_e;

    function automatic int reader_beats(input int data_w, input int word_w);
        return data_w / word_w;
    endfunction

endpackage

// File: rtl/register1024_reader.sv
// Snapshots a wide register image on start and streams it out LSB word first
// over a valid/ready handshake, with a one-cycle done pulse at the end.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for reader_start; outputs quiet
// SEND  | presenting shadow beats; advance on out_valid && out_ready
module register1024_reader
    import register1024_reader_pkg::*;
#(
    parameter int DATA_W = READER_DATA_W,
    parameter int WORD_W = READER_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reader_start,
    input  logic [DATA_W-1:0] reader_data_in,
    output logic              reader_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              reader_done
);

    localparam int BEATS = reader_beats(DATA_W, WORD_W);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [0:0] ST_IDLE = READER_IDLE;
    localparam logic [0:0] ST_SEND = READER_SEND;

    logic [0:0]        state;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] shadow_next;
    logic [CNT_W-1:0]  beat_cnt;
    logic              accept;

    assign shadow_next = shadow >> WORD_W;

    // Handshake outputs depend only on flops, never on out_ready.
    assign out_valid   = (state == ST_SEND);
    assign reader_busy = out_valid;
    assign out_last    = out_valid && (beat_cnt == LAST_BEAT);
    assign accept      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            beat_cnt    <= '0;
            out_data    <= '0;
            reader_done <= 1'b0;
        end else begin
            reader_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (reader_start) begin
                        shadow   <= reader_data_in;
                        out_data <= reader_data_in[WORD_W-1:0];
                        beat_cnt <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        if (out_last) begin
                            state       <= ST_IDLE;
                            reader_done <= 1'b1;
                            out_data    <= '0;
                        end else begin
                            shadow   <= shadow_next;
                            out_data <= shadow_next[WORD_W-1:0];
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
